// File: rtl/framebuffer.sv
// ---------------------------------------------------------------------------
// framebuffer
//   Double-buffered 16-bit pixel store. The GPU writes pixels into the back
//   bank while the scanout reads the front bank. A swap request is armed by
//   ctrl_swap and takes effect on the next rising edge of scan_vblank, so the
//   display never tears mid-frame.
//
// Ports
//   clk               : single clock, all state updates on its rising edge
//   rstn              : asynchronous active-low reset
//   fb_x, fb_y        : GPU write coordinate
//   fb_color          : GPU write pixel value
//   fb_write          : GPU write strobe (one pixel per cycle)
//   ctrl_swap         : request to exchange front and back banks
//   ctrl_swap_pending : a swap is armed and waiting for vblank
//   ctrl_front        : index of the displayed bank
//   scan_x, scan_y    : scanout read coordinate
//   scan_read         : scanout read strobe
//   scan_vblank       : vertical blanking level from display timing
//   scan_color        : read data, one cycle after scan_read
//   scan_valid        : scan_color is valid this cycle
// ---------------------------------------------------------------------------
module framebuffer #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  fb_x,
  input  logic [7:0]  fb_y,
  input  logic [15:0] fb_color,
  input  logic        fb_write,
  input  logic        ctrl_swap,
  output logic        ctrl_swap_pending,
  output logic        ctrl_front,
  input  logic [7:0]  scan_x,
  input  logic [7:0]  scan_y,
  input  logic        scan_read,
  input  logic        scan_vblank,
  output logic [15:0] scan_color,
  output logic        scan_valid
);

  localparam int PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int DEPTH  = 2 * PIXELS;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  swap_state_t state_reg;
  swap_state_t state_next;
  logic        front_reg;
  logic        vblank_prev_reg;
  logic        vblank_rise;
  logic        swap_fire;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  logic [15:0] mem [0:DEPTH-1];
  logic [15:0] rd_data_reg;
  logic        valid_reg;
  logic        rd_in_range_reg;

  // Linear word address of pixel (x,y) in the given bank.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic bank,
                                                 input logic [7:0] x,
                                                 input logic [7:0] y);
    logic [ADDR_W-1:0] base;
    base = bank ? ADDR_W'(PIXELS) : '0;
    return base + ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
  endfunction

  assign wr_in_range = ({24'd0, fb_x} < 32'(FB_WIDTH)) &&
                       ({24'd0, fb_y} < 32'(FB_HEIGHT));
  assign rd_in_range = ({24'd0, scan_x} < 32'(FB_WIDTH)) &&
                       ({24'd0, scan_y} < 32'(FB_HEIGHT));

  // Writes go to the back bank, reads to the front bank, both using the bank
  // index registered before this edge, so the two ports never collide.
  assign wr_addr = pix_addr(~front_reg, fb_x, fb_y);
  assign rd_addr = pix_addr(front_reg, scan_x, scan_y);

  // Out-of-range accesses are kept away from the array entirely.
  assign wr_en = rstn & fb_write & wr_in_range;
  assign rd_en = scan_read & rd_in_range;

  // ---------------------------------------------------------------------
  // Dual-port pixel memory with registered read; not cleared by reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= fb_color;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  // Read-side qualifiers; an out-of-range read still reports valid with 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg       <= 1'b0;
      rd_in_range_reg <= 1'b0;
    end else begin
      valid_reg       <= scan_read;
      rd_in_range_reg <= rd_in_range;
    end
  end

  assign scan_valid = valid_reg;
  assign scan_color = (valid_reg && rd_in_range_reg) ? rd_data_reg : 16'd0;

  // ---------------------------------------------------------------------
  // Swap FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      front_reg       <= 1'b0;
      vblank_prev_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      front_reg       <= front_reg ^ swap_fire;
      vblank_prev_reg <= scan_vblank;
    end
  end

  assign vblank_rise = scan_vblank & ~vblank_prev_reg;

  // Swap FSM: next-state logic. A vblank rise seen while IDLE is not
  // remembered, so a request always waits for a fresh rise.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ctrl_swap)   state_next = PENDING;
      PENDING: if (vblank_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Swap FSM: outputs
  always_comb begin
    ctrl_swap_pending = 1'b0;
    swap_fire         = 1'b0;
    if (state_reg == PENDING) begin
      ctrl_swap_pending = 1'b1;
      swap_fire         = vblank_rise;
    end
  end

  assign ctrl_front = front_reg;

endmodule

// File: doc/framebuffer.md
FRAMEBUFFER -- requirements
Module: framebuffer

Interface
REQ-001 Parameter FB_WIDTH, default 160, pixel columns per buffer.
REQ-002 Parameter FB_HEIGHT, default 120, pixel rows per buffer.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 fb_x  input  8  write column from the GPU.
REQ-006 fb_y  input  8  write row from the GPU.
REQ-007 fb_color  input  16  write pixel color.
REQ-008 fb_write  input  1  write strobe; one pixel per cycle while high.
REQ-009 ctrl_swap  input  1  request to exchange front and back buffers.
REQ-010 ctrl_swap_pending  output  1  high while an accepted swap waits for vblank.
REQ-011 ctrl_front  output  1  index of the current front (displayed) bank.
REQ-012 scan_x  input  8  scanout read column.
REQ-013 scan_y  input  8  scanout read row.
REQ-014 scan_read  input  1  scanout read strobe.
REQ-015 scan_vblank  input  1  vertical blanking level from the display timing.
REQ-016 scan_color  output  16  scanout read data.
REQ-017 scan_valid  output  1  scan_color is valid this cycle.

Function
REQ-018 Storage SHALL be two banks of FB_WIDTH*FB_HEIGHT 16-bit words; bank b, pixel (x,y) at word b*FB_WIDTH*FB_HEIGHT + y*FB_WIDTH + x, address width wide enough for 2*FB_WIDTH*FB_HEIGHT with no truncation.
REQ-019 Writes SHALL target the back bank (~ctrl_front); with fb_write high and fb_x<FB_WIDTH and fb_y<FB_HEIGHT, fb_color is stored at that rising edge.
REQ-020 Writes with fb_x>=FB_WIDTH or fb_y>=FB_HEIGHT SHALL be dropped with no memory change.
REQ-021 Reads SHALL target the front bank; scan_read high at edge N yields scan_color and scan_valid=1 during cycle N+1 (latency 1); scan_valid=0 in any cycle not following a scan_read.
REQ-022 Out-of-range reads SHALL return scan_color=0 with scan_valid=1.
REQ-023 Back-to-back reads SHALL be supported at one per cycle with no bubbles.
REQ-024 Bank selection for writes and reads SHALL use ctrl_front as registered before the edge in question.
REQ-025 Swap FSM states: IDLE, PENDING; ctrl_swap_pending=1 exactly in PENDING.
REQ-026 IDLE -> PENDING when ctrl_swap=1 at an edge.
REQ-027 PENDING -> IDLE on the first edge where scan_vblank=1 and its registered previous value=0 (rising edge); at that same edge ctrl_front toggles.
REQ-028 ctrl_swap while PENDING SHALL be ignored (no double swap, no queuing).
REQ-029 ctrl_swap and a vblank rising edge in the same cycle while IDLE: enter PENDING only; the swap waits for the next vblank rise.
REQ-030 scan_vblank held high when a swap is requested SHALL NOT trigger the swap; a fresh 0->1 transition is required.
REQ-031 fb_write in the swap cycle SHALL land in the pre-swap back bank; scan_read in the swap cycle SHALL return the pre-swap front bank.
REQ-032 Read and write SHALL proceed simultaneously in the same cycle without stall.

Reset
REQ-033 rstn low SHALL immediately force: FSM=IDLE, ctrl_swap_pending=0, ctrl_front=0, scan_valid=0, scan_color=0, vblank history=0.
REQ-034 Reset while PENDING SHALL cancel the swap; memory contents SHALL NOT be cleared by reset.
REQ-035 Inputs SHALL be ignored while rstn is low.

Verification
REQ-036 After reset, write (3,2)=0xABCD; swap; pulse scan_vblank 0->1; read (3,2) -> scan_valid=1 and scan_color=0xABCD one cycle after scan_read, ctrl_front=1.
REQ-037 Write (160,5)=0x1234 and (5,120)=0x1234; read (160,5) -> scan_color=0; after a completed swap read (5,119) -> prior contents unchanged.
REQ-038 ctrl_swap with scan_vblank already high -> ctrl_swap_pending=1, ctrl_front unchanged until vblank falls and rises again, then ctrl_front toggles and pending clears on that edge.
REQ-039 Three ctrl_swap pulses before one vblank rise -> exactly one toggle of ctrl_front.
REQ-040 Streaming reads (0..159,0) one per cycle concurrent with writes to (0..159,0) -> scan_valid high for 160 consecutive cycles, reads return front data, writes visible only after swap.
REQ-041 Assert rstn low while PENDING -> ctrl_swap_pending=0 and ctrl_front=0 asynchronously; after release a vblank rise causes no toggle.
